// File: rtl/counter_pkg.sv
// Shared constants for the loadable up/down counter family.
// Mode encoding and default width are common to the up-count and down-count variants.
package counter_pkg;

  localparam logic MODE_ROTR = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_rotr.sv
// Loadable down-counter with rotate-right mode, combinational borrow out and sticky underflow.
// Optional DOWN_COUNTER_AUTO_RELOAD_EN: underflow reloads the last loaded value instead of all-ones.
module down_counter_rotr
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             bco,
  output logic             uflow
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("down_counter_rotr: WIDTH must be in 2..16");
  end

  // Returns {underflow, next value}; wrap is the value taken when decrementing past zero.
  function automatic logic [WIDTH:0] next_value(
    input logic [WIDTH-1:0] cur,
    input logic             m,
    input logic [WIDTH-1:0] wrap
  );
    if (m == MODE_ROTR)
      return {1'b0, cur[0], cur[WIDTH-1:1]};
    else if (cur == '0)
      return {1'b1, wrap};
    else
      return {1'b0, cur - WIDTH'(1)};
  endfunction

  logic [WIDTH-1:0] wrap_value;
  logic [WIDTH:0]   step_val;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk) begin
    if (reset)
      reload_reg <= '0;
    else if (!load_n)
      reload_reg <= data_in;
  end

  assign wrap_value = reload_reg;
`else
  assign wrap_value = '1;
`endif

  always_comb begin
    step_val = next_value(data_out, mode, wrap_value);
  end

  // Unknown en/mode poisons the count in simulation; both are 2-state in hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      uflow    <= 1'b0;
    end else if (!load_n) begin
      data_out <= data_in;
      uflow    <= 1'b0;
    end else begin
      case (en)
        1'b0: begin
          data_out <= data_out;
        end
        1'b1: begin
          case (mode)
            1'b0, 1'b1: begin
              data_out <= step_val[WIDTH-1:0];
              if (step_val[WIDTH])
                uflow <= 1'b1;
            end
            default: data_out <= 'x;
          endcase
        end
        default: data_out <= 'x;
      endcase
    end
  end

  assign bco = en & (mode == MODE_DOWN) & (data_out == '0);

endmodule
